// File: rtl/da_ramp_sched_pkg.sv
// Shared constants and state encoding for the DAC setpoint ramp scheduler.
package da_ramp_sched_pkg;

  localparam int         NUM_CH    = 16;
  localparam logic [4:0] ADDR_STEP = 5'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/da_ramp_sched_step.sv
// Combinational slew limiter: moves one channel value toward its effective
// target by at most one step, never overshooting.
module da_ramp_step (
  input  logic [9:0] cur,
  input  logic [9:0] tgt,
  input  logic [9:0] step,
  output logic [9:0] nxt
);

  logic        up;
  logic [10:0] diff;

  // The 11-bit difference keeps the magnitude compare free of wrap-around.
  always_comb begin
    up   = tgt > cur;
    diff = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
    if ((step == 10'd0) || (diff <= {1'b0, step})) begin
      nxt = tgt;
    end else if (up) begin
      nxt = cur + step;
    end else begin
      nxt = cur - step;
    end
  end

endmodule

// File: rtl/da_ramp_sched.sv
// Slew-limited setpoint scheduler for the 16 DAC channels: sweeps one channel
// per cycle into a work set, then commits the whole set on a serializer RdAck.
module da_ramp_sched
  import da_ramp_sched_pkg::*;
#(
  parameter int         FRAME_DIV   = 4,
  parameter logic [9:0] STEP_INIT   = 10'd8,
  parameter int         ACK_TIMEOUT = 64
) (
  input  logic       Clk1,
  input  logic       aRst,
  input  logic       WrEn,
  input  logic [4:0] WrAddr,
  input  logic [9:0] WrData,
  input  logic       Enable,
  input  logic       RdAck,
  output logic [9:0] DA0Data,
  output logic [9:0] DA1Data,
  output logic [9:0] DA2Data,
  output logic [9:0] DA3Data,
  output logic [9:0] DA4Data,
  output logic [9:0] DA5Data,
  output logic [9:0] DA6Data,
  output logic [9:0] DA7Data,
  output logic [9:0] DA8Data,
  output logic [9:0] DA9Data,
  output logic [9:0] DA10Data,
  output logic [9:0] DA11Data,
  output logic [9:0] DA12Data,
  output logic [9:0] DA13Data,
  output logic [9:0] DA14Data,
  output logic [9:0] DA15Data,
  output logic       SweepBusy,
  output logic       Settled,
  output logic       RdAckLost
);

  localparam logic [3:0] FRAME_LAST = 4'(FRAME_DIV - 1);
  localparam logic [7:0] ACK_MAX    = 8'(ACK_TIMEOUT);

  logic [9:0]   tgt     [NUM_CH];
  logic [9:0]   work    [NUM_CH];
  logic [9:0]   out_val [NUM_CH];
  logic [9:0]   step_q;
  logic [3:0]   frame_cnt;
  logic [3:0]   idx;
  logic [7:0]   ack_cnt;
  sched_state_t state, state_nxt;
  logic         commit;
  logic         all_match;
  logic [9:0]   eff_tgt;
  logic [9:0]   step_nxt;

  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      for (int i = 0; i < NUM_CH; i++) tgt[i] <= '0;
      step_q <= STEP_INIT;
    end else if (WrEn) begin
      if (!WrAddr[4]) begin
        tgt[WrAddr[3:0]] <= WrData;
      end else if (WrAddr == ADDR_STEP) begin
        step_q <= WrData;
      end
    end
  end

  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      frame_cnt <= '0;
    end else if (RdAck) begin
      frame_cnt <= (frame_cnt == FRAME_LAST) ? 4'd0 : frame_cnt + 4'd1;
    end
  end

  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= (state == SWEEP) ? idx + 4'd1 : 4'd0;
    end
  end

  // A RdAck during SWEEP only advances frame_cnt; commits happen from WAIT.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE:  if (RdAck && (frame_cnt == FRAME_LAST)) state_nxt = SWEEP;
      SWEEP: if (idx == 4'd15) state_nxt = WAIT;
      WAIT: begin
        if (RdAck) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign eff_tgt = Enable ? tgt[idx] : 10'd0;

  da_ramp_step u_step (
    .cur  (out_val[idx]),
    .tgt  (eff_tgt),
    .step (step_q),
    .nxt  (step_nxt)
  );

  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        work[i]    <= '0;
        out_val[i] <= '0;
      end
    end else begin
      if (state == SWEEP) work[idx] <= step_nxt;
      if (commit) begin
        for (int i = 0; i < NUM_CH; i++) out_val[i] <= work[i];
      end
    end
  end

  // The RdAck that clears a lost flag is also allowed to commit a pending set.
  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      ack_cnt   <= '0;
      RdAckLost <= 1'b0;
    end else if (RdAck) begin
      ack_cnt   <= '0;
      RdAckLost <= 1'b0;
    end else if (ack_cnt == ACK_MAX) begin
      RdAckLost <= 1'b1;
    end else begin
      ack_cnt <= ack_cnt + 8'd1;
    end
  end

  always_comb begin
    all_match = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (out_val[i] != (Enable ? tgt[i] : 10'd0)) all_match = 1'b0;
    end
  end

  always_ff @(posedge Clk1 or posedge aRst) begin
    if (aRst) begin
      SweepBusy <= 1'b0;
      Settled   <= 1'b1;
    end else begin
      SweepBusy <= (state == SWEEP) || (state == WAIT);
      Settled   <= (state == IDLE) && all_match;
    end
  end

  assign DA0Data  = out_val[0];
  assign DA1Data  = out_val[1];
  assign DA2Data  = out_val[2];
  assign DA3Data  = out_val[3];
  assign DA4Data  = out_val[4];
  assign DA5Data  = out_val[5];
  assign DA6Data  = out_val[6];
  assign DA7Data  = out_val[7];
  assign DA8Data  = out_val[8];
  assign DA9Data  = out_val[9];
  assign DA10Data = out_val[10];
  assign DA11Data = out_val[11];
  assign DA12Data = out_val[12];
  assign DA13Data = out_val[13];
  assign DA14Data = out_val[14];
  assign DA15Data = out_val[15];

endmodule

// File: tb/tb_da_ramp_sched.sv
// Directed bench for da_ramp_sched: commit-by-commit vector table plus
// hand sequences for write/sweep races, watchdog and mid-sweep reset.
module tb_da_ramp_sched;

  typedef struct {
    logic       do_wr;
    logic [4:0] addr;
    logic [9:0] data;
    logic       en;
    int         ack_at;
    int         ch;
    int         exp_da;
    logic       chk_set;
    logic       exp_set;
  } vec_t;

  logic       Clk1 = 1'b0;
  logic       aRst;
  logic       WrEn;
  logic [4:0] WrAddr;
  logic [9:0] WrData;
  logic       Enable;
  logic       RdAck;
  logic [9:0] da [16];
  logic       SweepBusy, Settled, RdAckLost;

  int   checks = 0;
  int   failures = 0;
  int   ack_seen = 0;
  logic ack_en = 1'b1;
  logic [2:0] phase = 3'd0;
  vec_t vecs[$];

  da_ramp_sched dut (
    .Clk1(Clk1), .aRst(aRst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Enable(Enable), .RdAck(RdAck),
    .DA0Data(da[0]), .DA1Data(da[1]), .DA2Data(da[2]), .DA3Data(da[3]),
    .DA4Data(da[4]), .DA5Data(da[5]), .DA6Data(da[6]), .DA7Data(da[7]),
    .DA8Data(da[8]), .DA9Data(da[9]), .DA10Data(da[10]), .DA11Data(da[11]),
    .DA12Data(da[12]), .DA13Data(da[13]), .DA14Data(da[14]), .DA15Data(da[15]),
    .SweepBusy(SweepBusy), .Settled(Settled), .RdAckLost(RdAckLost)
  );

  always #5 Clk1 = ~Clk1;

  // One clock; RdAck pulses every 8th cycle while ack_en is set.
  task automatic tick();
    RdAck = ack_en && (phase == 3'd7);
    @(posedge Clk1);
    #1;
    if (RdAck) ack_seen++;
    phase = phase + 3'd1;
    RdAck = 1'b0;
    WrEn  = 1'b0;
  endtask

  task automatic waitAcks(input int target);
    int budget = 0;
    while (ack_seen < target && budget < 600) begin
      tick();
      budget++;
    end
    if (ack_seen < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_wait: got %0d acks expected %0d", ack_seen, target);
    end
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [9:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    tick();
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    Enable = v.en;
    if (v.do_wr) writeReg(v.addr, v.data);
    if (v.ack_at > 0) begin
      waitAcks(v.ack_at);
      tick();
      tick();
    end
    checkOutput($sformatf("da%0d@ack%0d", v.ch, v.ack_at), da[v.ch], v.exp_da);
    if (v.chk_set) checkOutput($sformatf("settled@ack%0d", v.ack_at), Settled, v.exp_set);
  endtask

  task automatic addVec(input logic w, input logic [4:0] a, input logic [9:0] d,
                        input logic en, input int at, input int ch, input int ex,
                        input logic cs, input logic es);
    vecs.push_back('{w, a, d, en, at, ch, ex, cs, es});
  endtask

  initial begin
    aRst = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0; Enable = 1'b1; RdAck = 1'b0;

    // Ramp ch3 to 100 with step 8: one commit per four acks, first at ack 7.
    addVec(1, 5'd3, 10'd100, 1, 0, 3, 0, 0, 0);
    addVec(1, 5'd16, 10'd8, 1, 0, 3, 0, 0, 0);
    for (int k = 1; k <= 13; k++)
      addVec(0, 0, 0, 1, 7 + 4 * (k - 1), 3, (k == 13) ? 100 : 8 * k, 1, k == 13);
    // Step 0 jumps straight to full scale.
    addVec(1, 5'd16, 10'd0, 1, 0, 15, 0, 0, 0);
    addVec(1, 5'd15, 10'd1023, 1, 0, 15, 0, 0, 0);
    addVec(0, 0, 0, 1, 59, 15, 1023, 1, 1);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 14, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 3, 100, 0, 0);
    // Disable with step 300 ramps down, re-enable ramps back up.
    addVec(1, 5'd16, 10'd300, 0, 0, 15, 1023, 0, 0);
    addVec(0, 0, 0, 0, 63, 15, 723, 1, 0);
    addVec(0, 0, 0, 0, 0, 3, 0, 0, 0);
    addVec(0, 0, 0, 0, 67, 15, 423, 0, 0);
    addVec(0, 0, 0, 0, 71, 15, 123, 0, 0);
    addVec(0, 0, 0, 0, 75, 15, 0, 1, 1);
    addVec(0, 0, 0, 1, 79, 15, 300, 1, 0);
    addVec(0, 0, 0, 1, 0, 3, 100, 0, 0);
    addVec(0, 0, 0, 1, 83, 15, 600, 0, 0);
    addVec(0, 0, 0, 1, 87, 15, 900, 0, 0);
    addVec(0, 0, 0, 1, 91, 15, 1023, 1, 1);

    @(posedge Clk1);
    #1 aRst = 1'b0;
    for (int i = 0; i < 16; i++) checkOutput($sformatf("reset_da%0d", i), da[i], 0);
    checkOutput("reset_busy", SweepBusy, 0);
    checkOutput("reset_settled", Settled, 1);
    checkOutput("reset_lost", RdAckLost, 0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Target written in the cycle its channel is swept waits for the next sweep.
    waitAcks(92);
    repeat (5) tick();
    writeReg(5'd5, 10'd50);
    checkOutput("busy_in_sweep", SweepBusy, 1);
    waitAcks(95); tick(); tick();
    checkOutput("race_da5_first", da[5], 0);
    checkOutput("race_da15_hold", da[15], 1023);
    waitAcks(99); tick(); tick();
    checkOutput("race_da5_next", da[5], 50);

    // RdAck stalls in WAIT: flag rises, outputs freeze, resumed RdAck commits.
    writeReg(5'd0, 10'd200);
    waitAcks(102);
    ack_en = 1'b0;
    repeat (40) tick();
    checkOutput("lost_early", RdAckLost, 0);
    repeat (40) tick();
    checkOutput("lost_set", RdAckLost, 1);
    checkOutput("lost_da0_frozen", da[0], 0);
    checkOutput("lost_busy", SweepBusy, 1);
    ack_en = 1'b1;
    waitAcks(103);
    checkOutput("lost_cleared", RdAckLost, 0);
    checkOutput("lost_commit_da0", da[0], 200);

    // Reset at idx 9 clears outputs at once and restores the step to 8.
    writeReg(5'd16, 10'd20);
    waitAcks(104);
    repeat (9) tick();
    aRst = 1'b1;
    #2;
    checkOutput("arst_da0", da[0], 0);
    checkOutput("arst_da15", da[15], 0);
    checkOutput("arst_busy", SweepBusy, 0);
    checkOutput("arst_settled", Settled, 1);
    ack_en = 1'b0;
    tick();
    aRst = 1'b0;
    ack_seen = 0;
    ack_en = 1'b1;
    writeReg(5'd2, 10'd100);
    waitAcks(3); tick(); tick();
    checkOutput("arst_no_sweep_3acks", SweepBusy, 0);
    waitAcks(4); tick(); tick();
    checkOutput("arst_sweep_4acks", SweepBusy, 1);
    waitAcks(7); tick(); tick();
    checkOutput("arst_step_reset_da2", da[2], 8);
    checkOutput("arst_idle_after", SweepBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
